// File: rtl/jtag_wb_bridge_pkg.sv
// jtag_wb_bridge_pkg
//   Shared definitions for the JTAG-to-Wishbone bridge:
//   - 3-bit command opcodes carried in reg_addr_q
//   - bit positions of the status word returned on reg_addr_d
//   - bus-master FSM state encoding
//   - byte shift-in helper used by the ADDR/DATA opcodes
package jtag_wb_bridge_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_ADDR   = 3'd1;
    localparam logic [2:0] OP_DATA   = 3'd2;
    localparam logic [2:0] OP_WRITE  = 3'd3;
    localparam logic [2:0] OP_READ   = 3'd4;
    localparam logic [2:0] OP_RBYTE  = 3'd5;
    localparam logic [2:0] OP_STATUS = 3'd6;
    localparam logic [2:0] OP_CLEAR  = 3'd7;

    localparam int ST_BUSY = 0;
    localparam int ST_ERR  = 1;
    localparam int ST_OVR  = 2;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUS  = 1'b1
    } state_e;

    // Shift a byte in at the LSB end; the oldest byte falls off the MSB.
    function automatic logic [31:0] shift_in_byte(input logic [31:0] word, input logic [7:0] b);
        return {word[23:0], b};
    endfunction

endpackage

// File: rtl/jtag_wb_bridge_if.sv
// jtag_wb_bridge_if
//   Wishbone B4 classic single-cycle bus bundle.
//   master modport: drives adr/dat_o/sel/cyc/stb/we, receives dat_i/ack/err.
//   slave modport : the mirror image.
interface jtag_wb_bridge_if;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/jtag_wb_bridge_tsync.sv
// jtag_wb_bridge_tsync
//   Toggle-in / pulse-out clock-domain crossing.
//   Ports: clk, reset (sync, active-high), tog_in (foreign-domain toggle),
//          pulse (one clk cycle high per toggle of tog_in).
//   tog_in passes SYNC_STAGES flops plus one edge flop; pulse is the XOR of
//   the last synchroniser stage and the edge flop, so a toggle produces a
//   pulse SYNC_STAGES clk edges after it lands, decoded on the next edge.
module jtag_wb_bridge_tsync #(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tog_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   edge_r;

    // Synchroniser chain; deliberately not reset so it keeps tracking the
    // foreign toggle while this domain is held in reset.
    always_ff @(posedge clk) begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], tog_in};
    end

    // Edge flop; on reset it simply re-aligns to the synchronised toggle so
    // no pulse is emitted for a toggle that happened before/while in reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_r <= sync_r[SYNC_STAGES-1];
        end else begin
            edge_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign pulse = sync_r[SYNC_STAGES-1] ^ edge_r;

endmodule

// File: rtl/jtag_wb_bridge.sv
// jtag_wb_bridge
//   Executes byte-wide commands shifted in through a JTAG DR core as single
//   Wishbone B4 classic master cycles in the system clock domain.
//   Ports:
//     clk, reset        system clock, synchronous active-high reset
//     jtck, jrstn       JTAG clock and TAP reset (active-low, sync to jtck)
//     reg_update        jtck-domain update strobe
//     reg_q, reg_addr_q command byte and opcode (jtck domain)
//     reg_d             return byte for the next JTAG capture
//     reg_addr_d        status {overrun, err, busy}
//     wb                Wishbone master port (jtag_wb_bridge_if.master)
//   Optional feature: define JTAG_WB_BRIDGE_AUTOINC_EN to post-increment the
//   address by 4 after every WRITE/READ that completes with ack.
module jtag_wb_bridge
    import jtag_wb_bridge_pkg::*;
#(
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       jtck,
    input  logic       jrstn,
    input  logic       reg_update,
    input  logic [7:0] reg_q,
    input  logic [2:0] reg_addr_q,
    output logic [7:0] reg_d,
    output logic [2:0] reg_addr_d,
    jtag_wb_bridge_if.master wb
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    // jtck domain
    logic [10:0] hold_r;
    logic        tog_r;

    // clk domain
    logic        cmd_stb_s;
    logic [2:0]  cmd_op_s;
    logic [7:0]  cmd_byte_s;
    state_e      state_r;
    logic [31:0] adr_r;
    logic [31:0] wdat_r;
    logic [31:0] rdat_r;
    logic        cyc_r;
    logic        we_r;
    logic [3:0]  sel_r;
    logic [15:0] timer_r;
    logic        err_r;
    logic        ovr_r;
    logic [7:0]  reg_d_r;
    logic [2:0]  reg_addr_d_r;
    logic [2:0]  status_s;

    // Capture each JTAG update into the hold register and flag it with a toggle.
    always_ff @(posedge jtck) begin
        if (!jrstn) begin
            hold_r <= 11'h000;
            tog_r  <= 1'b0;
        end else if (reg_update) begin
            hold_r <= {reg_addr_q, reg_q};
            tog_r  <= ~tog_r;
        end else begin
            hold_r <= hold_r;
            tog_r  <= tog_r;
        end
    end

    jtag_wb_bridge_tsync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_tsync (
        .clk    (clk),
        .reset  (reset),
        .tog_in (tog_r),
        .pulse  (cmd_stb_s)
    );

    // hold_r is quasi-static here: the next update is at least a full scan away.
    assign cmd_op_s   = hold_r[10:8];
    assign cmd_byte_s = hold_r[7:0];

    // Assemble the live status word.
    always_comb begin
        status_s         = 3'b000;
        status_s[ST_BUSY] = (state_r == S_BUS);
        status_s[ST_ERR]  = err_r;
        status_s[ST_OVR]  = ovr_r;
    end

    // Command decoder and Wishbone master FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            adr_r        <= 32'h0000_0000;
            wdat_r       <= 32'h0000_0000;
            rdat_r       <= 32'h0000_0000;
            cyc_r        <= 1'b0;
            we_r         <= 1'b0;
            sel_r        <= 4'h0;
            timer_r      <= 16'h0000;
            err_r        <= 1'b0;
            ovr_r        <= 1'b0;
            reg_d_r      <= 8'h00;
            reg_addr_d_r <= 3'b000;
        end else begin
            reg_addr_d_r <= status_s;
            case (state_r)
                S_IDLE: begin
                    if (cmd_stb_s) begin
                        case (cmd_op_s)
                            OP_ADDR:   adr_r  <= shift_in_byte(adr_r, cmd_byte_s);
                            OP_DATA:   wdat_r <= shift_in_byte(wdat_r, cmd_byte_s);
                            OP_WRITE: begin
                                cyc_r   <= 1'b1;
                                we_r    <= 1'b1;
                                sel_r   <= 4'hF;
                                timer_r <= 16'h0000;
                                state_r <= S_BUS;
                            end
                            OP_READ: begin
                                cyc_r   <= 1'b1;
                                we_r    <= 1'b0;
                                sel_r   <= 4'hF;
                                timer_r <= 16'h0000;
                                state_r <= S_BUS;
                            end
                            OP_RBYTE: begin
                                reg_d_r <= rdat_r[31:24];
                                rdat_r  <= {rdat_r[23:0], rdat_r[31:24]};
                            end
                            OP_STATUS: reg_d_r <= {5'b00000, status_s};
                            OP_CLEAR: begin
                                err_r <= 1'b0;
                                ovr_r <= 1'b0;
                            end
                            default: reg_d_r <= reg_d_r;
                        endcase
                    end
                end
                S_BUS: begin
                    // Only STATUS and CLEAR are honoured mid-cycle; anything
                    // else is dropped and flagged as an overrun.
                    if (cmd_stb_s) begin
                        case (cmd_op_s)
                            OP_STATUS: reg_d_r <= {5'b00000, status_s};
                            OP_CLEAR: begin
                                err_r <= 1'b0;
                                ovr_r <= 1'b0;
                            end
                            default: ovr_r <= 1'b1;
                        endcase
                    end
                    timer_r <= timer_r + 16'd1;
                    // Bus termination; written after the command handling so
                    // a bus error wins over a coincident CLEAR.
                    if (wb.wb_err_i) begin
                        err_r   <= 1'b1;
                        cyc_r   <= 1'b0;
                        we_r    <= 1'b0;
                        sel_r   <= 4'h0;
                        state_r <= S_IDLE;
                    end else if (wb.wb_ack_i) begin
                        if (!we_r) begin
                            rdat_r <= wb.wb_dat_i;
                        end
`ifdef JTAG_WB_BRIDGE_AUTOINC_EN
                        adr_r <= adr_r + 32'd4;
`endif
                        cyc_r   <= 1'b0;
                        we_r    <= 1'b0;
                        sel_r   <= 4'h0;
                        state_r <= S_IDLE;
                    end else if (timer_r == TMO_LAST) begin
                        err_r   <= 1'b1;
                        cyc_r   <= 1'b0;
                        we_r    <= 1'b0;
                        sel_r   <= 4'h0;
                        state_r <= S_IDLE;
                    end else begin
                        state_r <= S_BUS;
                    end
                end
                default: begin
                    cyc_r   <= 1'b0;
                    we_r    <= 1'b0;
                    sel_r   <= 4'h0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign reg_d       = reg_d_r;
    assign reg_addr_d  = reg_addr_d_r;
    assign wb.wb_adr_o = adr_r;
    assign wb.wb_dat_o = wdat_r;
    assign wb.wb_sel_o = sel_r;
    assign wb.wb_cyc_o = cyc_r;
    assign wb.wb_stb_o = cyc_r;
    assign wb.wb_we_o  = we_r;

endmodule
